mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It turns load/store control and ALU address into a valid/ready request to a data memory that may take several cycles. While an access is outstanding it stalls the pipeline. It performs byte-lane alignment and load extension, and registers the MEM/WB outputs.

Parameters:
ADDR_WIDTH, 64, width of mem_addr; taken from ALU_Result[ADDR_WIDTH-1:0]
WAIT_LIMIT, 255, max cycles in WAIT before bus timeout; 0 disables timeout

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
EXMEM_RegWrite  input  1  register write enable of MEM-stage instruction
EXMEM_MemToReg  input  1  writeback selects load data
EXMEM_MemRead  input  1  instruction is a load
EXMEM_MemWrite  input  1  instruction is a store
EXMEM_Funct3  input  3  access size/sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 3 LD/SD, 4 LBU, 5 LHU, 6 LWU
EXMEM_ALU_Result  input  64  effective address / ALU result
EXMEM_Read_Data_2  input  64  store data
EXMEM_Instruction_11_7  input  5  rd
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  1 = write
mem_addr  output  ADDR_WIDTH  address, bits [2:0] forced 0
mem_wdata  output  64  lane-shifted store data
mem_wstrb  output  8  byte strobes (0 for reads)
mem_resp_valid  input  1  read data valid
mem_rdata  input  64  read data
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
misaligned  output  1  one-cycle pulse: misaligned access dropped
bus_timeout  output  1  one-cycle pulse: read response timeout
MEMWB_RegWrite  output  1  registered
MEMWB_MemToReg  output  1  registered
MEMWB_Read_Data  output  64  registered extended load data
MEMWB_ALU_Result  output  64  registered
MEMWB_Instruction_11_7  output  5  registered rd

Behaviour:
- Clocking and reset: one clock, clock; reset is synchronous, active-high.
- Reset: state=IDLE, wait counter=0, load buffer=0. All registered outputs are 0 (MEMWB_*, misaligned, bus_timeout). mem_req_valid=0 and stall=0 by the next edge.
- Reset mid-access: the outstanding request is abandoned. A late mem_resp_valid seen in IDLE is ignored.
- access = MemRead | MemWrite. If both are set, treat it as a read.
- off = ALU_Result[2:0]. Misaligned when: size half and off[0]≠0; size word and off[1:0]≠0; size double and off≠0.
- Store strobes: SB 8'h01<<off; SH 8'h03<<off; SW 8'h0F<<off; SD 8'hFF.
- Store data: mem_wdata = Read_Data_2 << (8*off).
- Load extraction: rdata >> (8*off), then sign- or zero-extend per Funct3.
- stall is combinational: (IDLE & access) | REQ | WAIT.
- FSM:
  - IDLE, no access: stall=0.
  - IDLE, access and aligned: latch addr/we/wdata/wstrb/funct3/off → REQ.
  - IDLE, access and misaligned: no request; pulse misaligned; load buffer=0 → DONE.
  - REQ: mem_req_valid=1, outputs held stable until mem_req_ready. On the accepting edge a write → DONE (posted, no response) and a read → WAIT (counter cleared).
  - WAIT: mem_req_valid=0. mem_resp_valid → capture extracted data into load buffer → DONE. The counter increments each cycle. If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT with no response, load buffer=0, pulse bus_timeout → DONE. A response and the limit in the same cycle: the response wins.
  - DONE: stall=0 → IDLE. EX/MEM still holds the same instruction this cycle.
- MEMWB_* load from the current inputs (Read_Data from the load buffer) on every edge where stall=0, and hold while stall=1.
- Latency:
  - Non-memory op: 0 stall cycles.
  - Store: 1 + request wait cycles + 1 (DONE).
  - Load: adds response wait cycles.
  - Back-to-back accesses: DONE always inserts one IDLE evaluation of the next instruction.

Test Plan:
- ALU op (MemRead=MemWrite=0, ALU_Result=64'h1234, rd=5) → stall=0; next edge MEMWB_ALU_Result=64'h1234, MEMWB_Instruction_11_7=5.
- SB, addr 64'h1003, Read_Data_2=64'hAB, ready after 2 cycles → mem_wstrb=8'h08, mem_wdata=64'hAB000000, mem_addr=64'h1000; stall high 4 cycles.
- LB, addr 64'h2001, rdata=64'h0000_0000_0000_8000, response 3 cycles after accept → MEMWB_Read_Data=64'hFFFF_FFFF_FFFF_FF80; the same with LBU → 64'h80.
- LW at addr 64'h2002 → no mem_req_valid, misaligned pulses once, MEMWB_Read_Data=0, stall for 1 cycle.
- LD with no response, WAIT_LIMIT=4 → bus_timeout pulses after 4 WAIT cycles, then DONE and IDLE.
- Reset asserted while in WAIT → next edge: mem_req_valid=0, stall=0, MEMWB_*=0; a response arriving afterwards changes nothing.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and a multi-cycle memory.
// master: request/write side; slave: ready/response side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [63:0]           mem_wdata;
  logic [7:0]            mem_wstrb;
  logic                  mem_resp_valid;
  logic [63:0]           mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: load/store request FSM, lane alignment, load extension, MEM/WB regs.
// Ports: clock/reset, EXMEM_* in, bus (master), stall/misaligned/bus_timeout, MEMWB_* out.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemToReg,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic [2:0]  EXMEM_Funct3,
  input  logic [63:0] EXMEM_ALU_Result,
  input  logic [63:0] EXMEM_Read_Data_2,
  input  logic [4:0]  EXMEM_Instruction_11_7,
  mem_access_unit_if.master bus,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_timeout,
  output logic        MEMWB_RegWrite,
  output logic        MEMWB_MemToReg,
  output logic [63:0] MEMWB_Read_Data,
  output logic [63:0] MEMWB_ALU_Result,
  output logic [4:0]  MEMWB_Instruction_11_7
);

  localparam int CW =
    (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t state, state_n;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [63:0]           wdata_q;
  logic [7:0]            wstrb_q;
  logic [2:0]            f3_q;
  logic [2:0]            off_q;
  logic [CW-1:0]         cnt;
  logic [63:0]           ldbuf;

  logic        access;
  logic        mis;
  logic        hit;
  logic [2:0]  off;
  logic [7:0]  strb;
  logic [63:0] sh;
  logic [63:0] ld_val;

  assign access = EXMEM_MemRead | EXMEM_MemWrite;
  assign off    = EXMEM_ALU_Result[2:0];
  assign hit    = (WAIT_LIMIT != 0) && (cnt == LIM);

  // Funct3[1:0] encodes access size for both signed and unsigned loads.
  always_comb begin
    mis  = 1'b0;
    strb = 8'hFF;
    case (EXMEM_Funct3[1:0])
      2'd0: strb = 8'h01 << off;
      2'd1: begin
        mis  = off[0];
        strb = 8'h03 << off;
      end
      2'd2: begin
        mis  = |off[1:0];
        strb = 8'h0F << off;
      end
      default: mis = |off;
    endcase
  end

  always_comb begin
    sh     = bus.mem_rdata >> {off_q, 3'b000};
    ld_val = sh;
    case (f3_q)
      3'd0: ld_val = {{56{sh[7]}}, sh[7:0]};
      3'd1: ld_val = {{48{sh[15]}}, sh[15:0]};
      3'd2: ld_val = {{32{sh[31]}}, sh[31:0]};
      3'd4: ld_val = {56'd0, sh[7:0]};
      3'd5: ld_val = {48'd0, sh[15:0]};
      3'd6: ld_val = {32'd0, sh[31:0]};
      default: ld_val = sh;
    endcase
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_n = mis ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.mem_req_ready)
          state_n = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus.mem_resp_valid || hit)
          state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.mem_req_valid = (state == S_REQ);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wstrb     = wstrb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= S_IDLE;
      we_q                   <= 1'b0;
      addr_q                 <= '0;
      wdata_q                <= '0;
      wstrb_q                <= '0;
      f3_q                   <= '0;
      off_q                  <= '0;
      cnt                    <= '0;
      ldbuf                  <= '0;
      misaligned             <= 1'b0;
      bus_timeout            <= 1'b0;
      MEMWB_RegWrite         <= 1'b0;
      MEMWB_MemToReg         <= 1'b0;
      MEMWB_Read_Data        <= '0;
      MEMWB_ALU_Result       <= '0;
      MEMWB_Instruction_11_7 <= '0;
    end else begin
      state       <= state_n;
      misaligned  <= (state == S_IDLE) && access && mis;
      bus_timeout <= (state == S_WAIT) &&
                     !bus.mem_resp_valid && hit;
      if (state == S_IDLE && access) begin
        if (mis) begin
          ldbuf <= '0;
        end else begin
          // A combined read+write request is issued as a read.
          we_q    <= EXMEM_MemWrite & ~EXMEM_MemRead;
          addr_q  <= {EXMEM_ALU_Result[ADDR_WIDTH-1:3], 3'b000};
          wdata_q <= EXMEM_Read_Data_2 << {off, 3'b000};
          wstrb_q <= EXMEM_MemRead ? 8'h00 : strb;
          f3_q    <= EXMEM_Funct3;
          off_q   <= off;
        end
      end
      if (state == S_REQ) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 1'b1;
        if (bus.mem_resp_valid)
          ldbuf <= ld_val;
        else if (hit)
          ldbuf <= '0;
      end
      if (!stall) begin
        MEMWB_RegWrite         <= EXMEM_RegWrite;
        MEMWB_MemToReg         <= EXMEM_MemToReg;
        MEMWB_Read_Data        <= ldbuf;
        MEMWB_ALU_Result       <= EXMEM_ALU_Result;
        MEMWB_Instruction_11_7 <= EXMEM_Instruction_11_7;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a scripted memory responder.
// Expected MEM/WB bundles are queued at issue and popped at writeback.
module tb_mem_access_unit;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        rw, m2r, mrd, mwr;
  logic [2:0]  f3;
  logic [63:0] alu, rd2;
  logic [4:0]  rdi;
  logic        stall, misaligned, bus_timeout;
  logic        wb_rw, wb_m2r;
  logic [63:0] wb_rdata, wb_alu;
  logic [4:0]  wb_rd;

  mem_access_unit_if #(.ADDR_WIDTH(64)) bus ();

  mem_access_unit #(
    .ADDR_WIDTH(64),
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .EXMEM_RegWrite         (rw),
    .EXMEM_MemToReg         (m2r),
    .EXMEM_MemRead          (mrd),
    .EXMEM_MemWrite         (mwr),
    .EXMEM_Funct3           (f3),
    .EXMEM_ALU_Result       (alu),
    .EXMEM_Read_Data_2      (rd2),
    .EXMEM_Instruction_11_7 (rdi),
    .bus                    (bus),
    .stall                  (stall),
    .misaligned             (misaligned),
    .bus_timeout            (bus_timeout),
    .MEMWB_RegWrite         (wb_rw),
    .MEMWB_MemToReg         (wb_m2r),
    .MEMWB_Read_Data        (wb_rdata),
    .MEMWB_ALU_Result       (wb_alu),
    .MEMWB_Instruction_11_7 (wb_rd)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t         sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] m_ldbuf = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ld_model(
    input logic [63:0] d, input logic [2:0] o,
    input logic [2:0] fn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[8*o +: 8];
    h = d[8*o +: 16];
    w = d[8*o +: 32];
    case (fn)
      3'd0: return {{56{b[7]}}, b};
      3'd1: return {{48{h[15]}}, h};
      3'd2: return {{32{w[31]}}, w};
      3'd4: return {56'd0, b};
      3'd5: return {48'd0, h};
      3'd6: return {32'd0, w};
      default: return d;
    endcase
  endfunction

  // rdy: REQ cycles before ready; rsp: WAIT cycle of the
  // response, negative for none (bus timeout).
  task automatic run_op(
    input logic r, input logic w, input logic [2:0] fn,
    input logic [63:0] a, input logic [63:0] wd,
    input logic [63:0] rdv, input logic [4:0] rd,
    input logic wen, input logic mtr,
    input int rdy, input int rsp, input string nm);
    wb_t         e, g;
    logic        acc, isrd, bad, done;
    int          nb, st, est, nreq, nmis, nto, wc;
    logic [7:0]  es;
    logic [63:0] ewd;
    acc  = r | w;
    isrd = r;
    nb   = 1 << fn[1:0];
    bad  = acc && ((int'(a[2:0]) % nb) != 0);
    es   = 8'(((1 << nb) - 1) << a[2:0]);
    ewd  = wd << (8 * a[2:0]);
    est  = 0;
    if (acc && bad) begin
      est     = 1;
      m_ldbuf = '0;
    end else if (acc && !isrd) begin
      est = rdy + 2;
    end else if (acc) begin
      if (rsp < 0) begin
        est     = rdy + 2 + LIMIT;
        m_ldbuf = '0;
      end else begin
        est     = rdy + 3 + rsp;
        m_ldbuf = ld_model(rdv, a[2:0], fn);
      end
    end
    e.rdata = m_ldbuf;
    e.alu   = a;
    e.rd    = rd;
    e.rw    = wen;
    e.m2r   = mtr;
    sb.push_back(e);
    rw = wen; m2r = mtr; mrd = r; mwr = w;
    f3 = fn; alu = a; rd2 = wd; rdi = rd;
    bus.mem_rdata = rdv;
    st = 0; nreq = 0; nmis = 0; nto = 0;
    wc = -1; done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (misaligned)  nmis++;
      if (bus_timeout) nto++;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      st++;
      if (bus.mem_req_valid) begin
        if (nreq == 0) begin
          chk({nm, "_addr"}, bus.mem_addr,
              a & ~64'h7);
          chk({nm, "_we"}, bus.mem_we, w & ~r);
          chk({nm, "_strb"}, bus.mem_wstrb,
              isrd ? 8'h00 : es);
          if (!isrd)
            chk({nm, "_wdata"}, bus.mem_wdata, ewd);
        end
        if (nreq == rdy) begin
          bus.mem_req_ready = 1'b1;
          if (isrd) wc = 0;
        end
        nreq++;
      end else if (wc >= 0) begin
        if (wc == rsp) bus.mem_resp_valid = 1'b1;
        wc++;
      end
      @(negedge clock);
    end
    if (!done) chk({nm, "_hang"}, 1'b1, 1'b0);
    chk({nm, "_stall"}, st, est);
    chk({nm, "_reqcyc"}, nreq,
        (acc && !bad) ? rdy + 1 : 0);
    chk({nm, "_mis"}, nmis, bad ? 1 : 0);
    chk({nm, "_tmo"}, nto,
        (acc && !bad && isrd && rsp < 0) ? 1 : 0);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    chk({nm, "_wb_rdata"}, wb_rdata, g.rdata);
    chk({nm, "_wb_alu"}, wb_alu, g.alu);
    chk({nm, "_wb_rd"}, wb_rd, g.rd);
    chk({nm, "_wb_ctl"}, {wb_rw, wb_m2r},
        {g.rw, g.m2r});
    chk({nm, "_pulse_end"},
        {misaligned, bus_timeout}, 2'b00);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    rw = 0; m2r = 0; mrd = 0; mwr = 0;
    f3 = 0; alu = 0; rd2 = 0; rdi = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    repeat (3) @(negedge clock);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bus.mem_req_valid, 1'b0);
    chk("rst_wb", {wb_rw, wb_m2r, wb_rdata, wb_alu, wb_rd,
                   misaligned, bus_timeout}, '0);
    reset = 1'b0;

    run_op(0, 0, 3'd0, 64'h1234, 0, 0, 5'd5,
           1, 0, 0, 0, "alu");
    run_op(0, 1, 3'd0, 64'h1003, 64'hAB, 0, 5'd0,
           0, 0, 2, 0, "sb");
    run_op(1, 0, 3'd0, 64'h2001, 0, 64'h8000, 5'd6,
           1, 1, 0, 2, "lb");
    run_op(1, 0, 3'd4, 64'h2001, 0, 64'h8000, 5'd7,
           1, 1, 1, 2, "lbu");
    run_op(1, 0, 3'd2, 64'h2002, 0, 64'h5555, 5'd8,
           1, 1, 0, 0, "lw_mis");
    run_op(1, 0, 3'd3, 64'h2008, 0, 64'h1, 5'd9,
           1, 1, 1, -1, "ld_tmo");
    run_op(0, 1, 3'd1, 64'h3006, 64'hBEEF, 0, 5'd0,
           0, 0, 1, 0, "sh");
    run_op(1, 0, 3'd5, 64'h4006, 0,
           64'hBEEF_0000_0000_0000, 5'd10,
           1, 1, 0, 0, "lhu");
    run_op(1, 0, 3'd1, 64'h4006, 0,
           64'hBEEF_0000_0000_0000, 5'd11,
           1, 1, 3, 1, "lh");
    run_op(0, 1, 3'd3, 64'h5000, 64'h0123_4567_89AB_CDEF,
           0, 5'd0, 0, 0, 0, 0, "sd");
    run_op(1, 0, 3'd6, 64'h6004, 0,
           64'h8765_4321_0000_0000, 5'd12,
           1, 1, 0, 3, "lwu");
    run_op(1, 0, 3'd2, 64'h6004, 0,
           64'h8765_4321_0000_0000, 5'd13,
           1, 1, 2, 0, "lw");
    run_op(0, 0, 3'd0, 64'h77, 0, 0, 5'd14,
           1, 1, 0, 0, "alu_ld");
    run_op(0, 1, 3'd2, 64'h7001, 64'h1, 0, 5'd0,
           0, 0, 0, 0, "sw_mis");
    run_op(1, 1, 3'd3, 64'h8000, 64'hFF,
           64'hCAFE_F00D_0000_0001, 5'd15,
           1, 1, 0, 1, "rw_both");

    // Abandon an outstanding load with reset while in WAIT.
    rw = 1; m2r = 1; mrd = 1; mwr = 0;
    f3 = 3'd3; alu = 64'h9000; rdi = 5'd16;
    @(negedge clock);
    #1;
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    #1;
    bus.mem_req_ready = 1'b0;
    chk("pre_rst_wait", {stall, bus.mem_req_valid},
        2'b10);
    reset = 1'b1;
    rw = 0; m2r = 0; mrd = 0; mwr = 0;
    m_ldbuf = '0;
    @(posedge clock);
    #1;
    chk("mid_rst_req", bus.mem_req_valid, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_wb", {wb_rw, wb_m2r, wb_rdata,
                       wb_alu, wb_rd}, '0);
    @(negedge clock);
    reset = 1'b0;
    bus.mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.mem_resp_valid = 1'b1;
    @(negedge clock);
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("late_rsp_stall", stall, 1'b0);
    chk("late_rsp_req", bus.mem_req_valid, 1'b0);
    @(negedge clock);
    run_op(0, 0, 3'd0, 64'h42, 0, 0, 5'd17,
           1, 1, 0, 0, "post_rst");
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
